ets_phase_sweeper: RTL and testbench

Parametrised equivalent-time-sampling (ETS) sweep controller for the anti-probe datapath. It runs in the free-running clock domain and steps the MMCM dynamic phase shifter through a programmed number of positions using the ps_en/ps_done handshake. At each position it accumulates comparator hits over a power-of-two window for several channels at once. It then streams per-channel hit counts to the MCU through a valid/ready port, replacing single-bit, single-channel comparator capture.

---
 rtl/ets_phase_sweeper.sv | 104 ++++++++++
 tb/tb_ets_phase_sweeper.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ets_phase_sweeper.sv
// ets_phase_sweeper: equivalent-time-sampling sweep controller that steps the MMCM phase shifter
// and streams per-channel comparator hit counts for every phase position.
module ets_phase_sweeper #(
    parameter int NUM_CH      = 2,
    parameter int STEPS       = 256,
    parameter int AVG_LOG2    = 4,
    parameter int SETTLE_CYC  = 16,
    parameter int PS_TIMEOUT  = 1024,
    parameter bit RETURN_HOME = 1'b1,
    localparam int CW  = AVG_LOG2 + 1,
    localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic              free_run_clk,
    input  logic              free_run_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [NUM_CH-1:0] cmp_data,
    output logic              ps_en,
    output logic              ps_incdec,
    input  logic              ps_done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CW-1:0]     res_count,
    output logic [CHW-1:0]    res_ch,
    output logic [15:0]       res_step,
    output logic              busy,
    output logic              done,
    output logic              ps_err
);
    localparam int NACC = 1 << AVG_LOG2;
    localparam int TMA  = SETTLE_CYC > NACC ? SETTLE_CYC : NACC;
    localparam int TMAX = TMA > PS_TIMEOUT ? TMA : PS_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, SETTLE, ACCUM, EMIT, SHIFT, WAIT_PS, UNWIND, UNWAIT} state_t;

    state_t         state, state_nxt, abort_dst;
    logic [TW-1:0]  tmr;
    logic [15:0]    step;
    logic [CW-1:0]  cnt [NUM_CH];
    logic [CW-1:0]  cnt_nxt [NUM_CH];
    logic [CHW-1:0] ch_nxt;
    logic           tmo, last_ch, last_step;

    // The timeout timer starts with the ps_en cycle and keeps running into the wait state.
    always_comb begin
        tmo       = (state == WAIT_PS || state == UNWAIT) && !ps_done && tmr == TW'(PS_TIMEOUT - 1);
        last_ch   = res_ch == CHW'(NUM_CH - 1);
        last_step = step == 16'(STEPS - 1);
        abort_dst = RETURN_HOME && step != 16'd0 ? UNWIND : IDLE;
        ch_nxt    = state != EMIT ? '0 : res_ch + CHW'(res_ready);
        for (int c = 0; c < NUM_CH; c++)
            cnt_nxt[c] = state == ACCUM ? cnt[c] + CW'(cmp_data[c]) : state == SETTLE ? '0 : cnt[c];
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? SETTLE : IDLE;
            SETTLE:  state_nxt = abort ? abort_dst : tmr == TW'(SETTLE_CYC - 1) ? ACCUM : SETTLE;
            ACCUM:   state_nxt = abort ? abort_dst : tmr == TW'(NACC - 1) ? EMIT : ACCUM;
            EMIT:    state_nxt = abort ? abort_dst : !(res_ready && last_ch) ? EMIT :
                                 !last_step ? SHIFT : RETURN_HOME ? UNWIND : IDLE;
            SHIFT:   state_nxt = WAIT_PS;
            WAIT_PS: state_nxt = ps_done ? (abort ? (RETURN_HOME ? UNWIND : IDLE) : SETTLE) :
                                 tmo ? IDLE : WAIT_PS;
            UNWIND:  state_nxt = UNWAIT;
            UNWAIT:  state_nxt = ps_done ? (step == 16'd1 ? IDLE : UNWIND) : tmo ? IDLE : UNWAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge free_run_clk or negedge free_run_rst_n) begin
        if (!free_run_rst_n) begin
            state     <= IDLE;
            tmr       <= '0;
            step      <= '0;
            cnt       <= '{default: '0};
            ps_en     <= 1'b0;
            ps_incdec <= 1'b0;
            res_valid <= 1'b0;
            res_count <= '0;
            res_ch    <= '0;
            res_step  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ps_err    <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmr       <= state_nxt == state || state_nxt == WAIT_PS || state_nxt == UNWAIT ? tmr + 1'b1 : '0;
            step      <= state == IDLE ? '0 : state == WAIT_PS && ps_done ? step + 16'd1 :
                         state == UNWAIT && ps_done ? step - 16'd1 : step;
            cnt       <= cnt_nxt;
            ps_en     <= state_nxt == SHIFT || state_nxt == UNWIND;
            ps_incdec <= state_nxt == SHIFT;
            res_valid <= state_nxt == EMIT;
            if (state_nxt == EMIT) begin
                res_ch    <= ch_nxt;
                res_count <= cnt_nxt[ch_nxt];
                res_step  <= step;
            end
            busy      <= state_nxt != IDLE;
            done      <= state != IDLE && state_nxt == IDLE;
            ps_err    <= state == IDLE && start ? 1'b0 : tmo ? 1'b1 : ps_err;
        end
    end
endmodule

// File: tb/tb_ets_phase_sweeper.sv
// tb_ets_phase_sweeper: randomized sweeps checked against a cycle-stamped model of
// accumulation windows, beat order and phase-shift handshakes.
module tb_ets_phase_sweeper;
    localparam int NUM_CH     = 2;
    localparam int STEPS      = 4;
    localparam int AVG_LOG2   = 3;
    localparam int SETTLE_CYC = 4;
    localparam int PS_TIMEOUT = 16;
    localparam int NACC       = 1 << AVG_LOG2;
    localparam int MAXC       = 8192;

    logic              free_run_clk = 1'b0;
    logic              free_run_rst_n = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              ps_done = 1'b0;
    logic              res_ready = 1'b0;
    logic [NUM_CH-1:0] cmp_data = '0;
    logic              ps_en, ps_incdec, res_valid, busy, done, ps_err;
    logic [AVG_LOG2:0] res_count;
    logic [0:0]        res_ch;
    logic [15:0]       res_step;

    int                total = 0;
    int                bad = 0;
    int                cyc = 0;
    bit                err_exp = 1'b0;
    logic [NUM_CH-1:0] hist [MAXC];

    ets_phase_sweeper #(
        .NUM_CH(NUM_CH), .STEPS(STEPS), .AVG_LOG2(AVG_LOG2), .SETTLE_CYC(SETTLE_CYC),
        .PS_TIMEOUT(PS_TIMEOUT), .RETURN_HOME(1'b1)
    ) dut (
        .free_run_clk(free_run_clk), .free_run_rst_n(free_run_rst_n), .start(start), .abort(abort),
        .cmp_data(cmp_data), .ps_en(ps_en), .ps_incdec(ps_incdec), .ps_done(ps_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count), .res_ch(res_ch),
        .res_step(res_step), .busy(busy), .done(done), .ps_err(ps_err)
    );

    always #5 free_run_clk = ~free_run_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge free_run_clk);
        @(negedge free_run_clk);
        cyc++;
    endtask

    function automatic logic [31:0] outs();
        return 32'({ps_en, ps_incdec, res_valid, res_count, res_ch, res_step, busy, done, ps_err});
    endfunction

    task automatic reset_mid_sweep();
        bit seen = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        ps_done = 1'b0;
        res_ready = 1'b0;
        free_run_rst_n = 1'b0;
        #1;
        check("rst_async", outs(), 0);
        tick();
        tick();
        check("rst_hold", outs(), 0);
        free_run_rst_n = 1'b1;
        ps_done = 1'b1;
        tick();
        ps_done = 1'b0;
        repeat (8) begin
            seen = seen | busy | ps_en;
            tick();
        end
        check("stale_ps_done", 32'(seen), 0);
        err_exp = 1'b0;
    endtask

    // mode: 0 plain, 1 forced 5-cycle stall, 2 withheld ps_done, 3 abort in step 2, 4 reset in WAIT_PS
    task automatic sweep(input int mode);
        int win [STEPS];
        int beats = 0, incs = 0, decs = 0, pend = -1, acc_at = -10, psd_at = -10;
        int abort_at = -10, tmo_at = -10, rst_at = -10, stall = 0, s, e;
        bit outst = 1'b0, dec_pend = 1'b0, prev_v = 1'b0, prev_r = 1'b1, prev_busy = 1'b1;
        bit fin = 1'b0, stalled = 1'b0;
        logic [31:0] prev_pay = '0;
        check("err_sticky", 32'(ps_err), 32'(err_exp));
        start = 1'b1;
        hist[cyc] = cmp_data;
        win[0] = cyc + 1 + SETTLE_CYC;
        tick();
        start = 1'b0;
        check("start_busy", 32'({busy, ps_err}), 32'b10);
        for (int k = 0; k < 2000 && !fin; k++) begin
            if (cyc == rst_at) begin
                reset_mid_sweep();
                return;
            end
            if (done) begin
                fin = 1'b1;
                break;
            end
            s = beats / NUM_CH < STEPS ? beats / NUM_CH : STEPS - 1;
            if (res_valid && !prev_v)
                check("valid_lat", cyc, win[s] + NACC);
            if (prev_v && !prev_r)
                check("hold", 32'({res_valid, res_count, res_ch, res_step}), prev_pay);
            if (ps_en) begin
                check("ps_overlap", 32'(outst), 0);
                outst = 1'b1;
                pend = cyc + int'($urandom_range(1, 5));
                dec_pend = !ps_incdec;
                if (ps_incdec) begin
                    check("inc_lat", cyc, acc_at + 1);
                    incs++;
                    if (mode == 2 && incs == 1) begin
                        pend = -1;
                        tmo_at = cyc + PS_TIMEOUT;
                    end
                    if (mode == 4 && incs == 1)
                        rst_at = cyc + 1;
                end else begin
                    check("dec_lat", cyc, decs == 0 ? (mode == 3 ? abort_at : acc_at) + 1 : psd_at + 1);
                    decs++;
                end
            end
            ps_done = (outst && cyc == pend) || (!outst && $urandom_range(0, 15) == 0);
            if (outst && cyc == pend) begin
                outst = 1'b0;
                psd_at = cyc;
                if (!dec_pend && incs < STEPS)
                    win[incs] = cyc + 1 + SETTLE_CYC;
            end
            abort = mode == 3 && incs == 2 && !outst && cyc == win[2] + 3;
            if (abort)
                abort_at = cyc;
            start = busy && $urandom_range(0, 15) == 0;
            if (mode == 1 && res_valid && beats == 3 && !stalled) begin
                stalled = 1'b1;
                stall = 5;
            end
            res_ready = stall > 0 ? 1'b0 : $urandom_range(0, 3) != 0;
            if (stall > 0)
                stall--;
            if (res_valid && res_ready) begin
                e = 0;
                for (int i = 0; i < NACC; i++)
                    e += int'(hist[win[s] + i][beats % NUM_CH]);
                check("count", 32'(res_count), e);
                check("chan", 32'(res_ch), beats % NUM_CH);
                check("step", 32'(res_step), s);
                beats++;
                acc_at = cyc;
            end
            cmp_data = NUM_CH'($urandom);
            hist[cyc] = cmp_data;
            prev_v = res_valid;
            prev_r = res_ready;
            prev_pay = 32'({1'b1, res_count, res_ch, res_step});
            prev_busy = busy;
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        ps_done = 1'b0;
        res_ready = 1'b0;
        check("finished", 32'(fin), 1);
        check("done_busy_fall", 32'({busy, prev_busy}), 32'b01);
        if (mode == 2) begin
            check("tmo_at", cyc, tmo_at);
            check("tmo_err", 32'(ps_err), 1);
            check("tmo_incs", incs, 1);
            check("tmo_beats", beats, NUM_CH);
        end else begin
            check("done_at", cyc, psd_at + 1);
            check("beats", beats, (mode == 3 ? 2 : STEPS) * NUM_CH);
            check("incs", incs, mode == 3 ? 2 : STEPS - 1);
            check("decs", decs, mode == 3 ? 2 : STEPS - 1);
            check("err_clear", 32'(ps_err), 0);
        end
        err_exp = mode == 2;
        hist[cyc] = cmp_data;
        tick();
        check("done_pulse", 32'({done, busy, ps_en}), 0);
    endtask

    initial begin
        #1;
        free_run_rst_n = 1'b0;
        #1;
        check("reset_outs", outs(), 0);
        @(negedge free_run_clk);
        @(negedge free_run_clk);
        free_run_rst_n = 1'b1;
        ps_done = 1'b1;
        tick();
        ps_done = 1'b0;
        tick();
        check("idle_outs", outs(), 0);
        sweep(0);
        sweep(1);
        sweep(2);
        sweep(0);
        sweep(3);
        sweep(4);
        sweep(0);
        sweep(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
